sr_latch: RTL and testbench

SR_LATCH -- requirements
Module: sr_latch

---
 rtl/sr_latch_pkg.sv | 33 +++
 rtl/sr_latch_cell.sv | 60 ++++++
 rtl/sr_latch.sv | 38 +++
 tb/tb_sr_latch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types for the clocked SR storage block: S=R=1 priority policy and default width.
// Optional feature macro used by this slice: SR_LATCH_CONFLICT_DETECT_EN.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        PRIO_RESET = 2'd0,
        PRIO_SET   = 2'd1,
        PRIO_HOLD  = 2'd2
    } sr_prio_e;

    localparam int SR_DEFAULT_WIDTH = 1;

    // Next stored value for one bit; S=R=1 is resolved by the priority policy.
    function automatic logic sr_next(input logic cur, input logic set, input logic clr,
                                     input sr_prio_e prio);
        logic nxt;
        nxt = cur;
        case ({set, clr})
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b11: begin
                case (prio)
                    PRIO_SET:   nxt = 1'b1;
                    PRIO_HOLD:  nxt = cur;
                    default:    nxt = 1'b0;
                endcase
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_latch_cell.sv
// Single registered SR bit (module sr_cell). Conflict flag port exists only when
// SR_LATCH_CONFLICT_DETECT_EN is defined.
import sr_latch_pkg::*;

module sr_cell #(
    parameter sr_prio_e PRIORITY = PRIO_RESET
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qn
`ifdef SR_LATCH_CONFLICT_DETECT_EN
    ,
    output logic conflict
`endif
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = sr_next(q_q, s, r, PRIORITY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    // Both outputs come straight from the flop, so qn tracks ~q even through reset.
    assign q  = q_q;
    assign qn = ~q_q;

`ifdef SR_LATCH_CONFLICT_DETECT_EN
    logic conflict_q;
    logic conflict_d;

    always_comb begin
        conflict_d = s & r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict = conflict_q;
`else
    // Without conflict detection the cell is just the priority-resolved flop above.
`endif

endmodule

// File: rtl/sr_latch.sv
// WIDTH independent clocked SR bits, one sr_cell per bit.
// Optional conflict port enabled by SR_LATCH_CONFLICT_DETECT_EN.
import sr_latch_pkg::*;

module sr_latch #(
    parameter int       WIDTH    = SR_DEFAULT_WIDTH,
    parameter sr_prio_e PRIORITY = PRIO_RESET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
`ifdef SR_LATCH_CONFLICT_DETECT_EN
    ,
    output logic [WIDTH-1:0] conflict
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_cell #(
            .PRIORITY(PRIORITY)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .s       (s[i]),
            .r       (r[i]),
            .q       (q[i]),
            .qn      (qn[i])
`ifdef SR_LATCH_CONFLICT_DETECT_EN
            ,
            .conflict(conflict[i])
`endif
        );
    end

endmodule

// File: tb/tb_sr_latch.sv
// Directed self-checking bench for sr_latch: a 4-bit PRIO_RESET instance plus
// 1-bit PRIO_SET and PRIO_HOLD instances for the S=R=1 policies.
import sr_latch_pkg::*;

module tb_sr_latch;

    logic       clk;
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] q;
    logic [3:0] qn;
    logic       s1;
    logic       r1;
    logic       q_set, qn_set, q_hold, qn_hold;
`ifdef SR_LATCH_CONFLICT_DETECT_EN
    logic [3:0] conflict;
    logic       conflict_set, conflict_hold;
`endif

    int checks = 0;
    int errors = 0;

    sr_latch #(.WIDTH(4), .PRIORITY(PRIO_RESET)) dut (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .qn(qn)
`ifdef SR_LATCH_CONFLICT_DETECT_EN
        , .conflict(conflict)
`endif
    );

    sr_latch #(.WIDTH(1), .PRIORITY(PRIO_SET)) dut_set (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(q_set), .qn(qn_set)
`ifdef SR_LATCH_CONFLICT_DETECT_EN
        , .conflict(conflict_set)
`endif
    );

    sr_latch #(.WIDTH(1), .PRIORITY(PRIO_HOLD)) dut_hold (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(q_hold), .qn(qn_hold)
`ifdef SR_LATCH_CONFLICT_DETECT_EN
        , .conflict(conflict_hold)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s = 4'h0; r = 4'h0; s1 = 1'b0; r1 = 1'b0;
        step();
        checks++;
        if (q !== 4'h0 || qn !== 4'hF) begin
            errors++; $display("FAIL reset_edge: q=%b qn=%b expected q=0000 qn=1111", q, qn);
        end
        checks++;
        if (q_set !== 1'b0 || qn_set !== 1'b1 || q_hold !== 1'b0 || qn_hold !== 1'b1) begin
            errors++; $display("FAIL reset_aux: q_set=%b qn_set=%b q_hold=%b qn_hold=%b expected 0/1/0/1",
                               q_set, qn_set, q_hold, qn_hold);
        end
`ifdef SR_LATCH_CONFLICT_DETECT_EN
        checks++;
        if (conflict !== 4'h0) begin
            errors++; $display("FAIL reset_conflict: conflict=%b expected 0000", conflict);
        end
`endif
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q !== 4'h0 || qn !== 4'hF) begin
                errors++; $display("FAIL reset_idle[%0d]: q=%b qn=%b expected q=0000 qn=1111", i, q, qn);
            end
        end
    endtask

    task automatic test_set_hold();
        s = 4'hF;
        step();
        s = 4'h0;
        checks++;
        if (q !== 4'hF || qn !== 4'h0) begin
            errors++; $display("FAIL set: q=%b qn=%b expected q=1111 qn=0000", q, qn);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (q !== 4'hF || qn !== 4'h0) begin
                errors++; $display("FAIL set_hold[%0d]: q=%b qn=%b expected q=1111 qn=0000", i, q, qn);
            end
        end
    endtask

    task automatic test_clear_hold();
        r = 4'hF;
        step();
        r = 4'h0;
        checks++;
        if (q !== 4'h0 || qn !== 4'hF) begin
            errors++; $display("FAIL clear: q=%b qn=%b expected q=0000 qn=1111", q, qn);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (q !== 4'h0 || qn !== 4'hF) begin
                errors++; $display("FAIL clear_hold[%0d]: q=%b qn=%b expected q=0000 qn=1111", i, q, qn);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] s_vec [4];
        logic [3:0] r_vec [4];
        logic [3:0] q_exp [4];
        s_vec = '{4'hF, 4'h0, 4'hF, 4'h0};
        r_vec = '{4'h0, 4'hF, 4'h0, 4'hF};
        q_exp = '{4'hF, 4'h0, 4'hF, 4'h0};
        for (int i = 0; i < 4; i++) begin
            s = s_vec[i]; r = r_vec[i];
            checks++;
            if (q !== ((i == 0) ? 4'h0 : q_exp[i-1])) begin
                errors++; $display("FAIL alt_latency[%0d]: q=%b changed before the edge", i, q);
            end
            step();
            checks++;
            if (q !== q_exp[i] || qn !== ~q_exp[i]) begin
                errors++; $display("FAIL alternation[%0d]: q=%b qn=%b expected q=%b", i, q, qn, q_exp[i]);
            end
        end
        s = 4'h0; r = 4'h0;
    endtask

    task automatic test_glitch();
        // A request that rises and falls between edges must be ignored.
        s = 4'hF;
        #3;
        s = 4'h0;
        step();
        checks++;
        if (q !== 4'h0) begin
            errors++; $display("FAIL glitch_set: q=%b expected 0000", q);
        end
    endtask

    task automatic test_conflict();
        // Bring main to 1111 and the hold instance to 1 first.
        s = 4'hF; s1 = 1'b1;
        step();
        s = 4'hF; r = 4'hF; s1 = 1'b0; r1 = 1'b0;
        step();
        checks++;
        if (q !== 4'h0 || qn !== 4'hF) begin
            errors++; $display("FAIL conflict_prio_reset: q=%b qn=%b expected q=0000", q, qn);
        end
        // Aux: hold instance at 1, conflict -> stays 1; set instance already 1.
        s1 = 1'b1; r1 = 1'b1; s = 4'h0; r = 4'h0;
        step();
        checks++;
        if (q_hold !== 1'b1) begin
            errors++; $display("FAIL conflict_hold_1: q=%b expected 1", q_hold);
        end
`ifdef SR_LATCH_CONFLICT_DETECT_EN
        checks++;
        if (conflict !== 4'h0 || conflict_hold !== 1'b1 || conflict_set !== 1'b1) begin
            errors++; $display("FAIL conflict_flag: main=%b set=%b hold=%b expected 0000/1/1",
                               conflict, conflict_set, conflict_hold);
        end
`endif
        // Clear both aux instances, then conflict from 0.
        s1 = 1'b0; r1 = 1'b1;
        step();
`ifdef SR_LATCH_CONFLICT_DETECT_EN
        checks++;
        if (conflict_hold !== 1'b0 || conflict_set !== 1'b0) begin
            errors++; $display("FAIL conflict_one_cycle: set=%b hold=%b expected 0/0", conflict_set, conflict_hold);
        end
`endif
        s1 = 1'b1; r1 = 1'b1;
        step();
        checks++;
        if (q_set !== 1'b1 || qn_set !== 1'b0) begin
            errors++; $display("FAIL conflict_prio_set: q=%b qn=%b expected q=1", q_set, qn_set);
        end
        checks++;
        if (q_hold !== 1'b0 || qn_hold !== 1'b1) begin
            errors++; $display("FAIL conflict_hold_0: q=%b qn=%b expected q=0", q_hold, qn_hold);
        end
        s1 = 1'b0; r1 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        s = 4'hF;
        step();
        checks++;
        if (q !== 4'hF) begin
            errors++; $display("FAIL mid_pre: q=%b expected 1111", q);
        end
        rst = 1'b1;
        step();
        checks++;
        if (q !== 4'h0 || qn !== 4'hF) begin
            errors++; $display("FAIL mid_reset: q=%b qn=%b expected q=0000 qn=1111", q, qn);
        end
        rst = 1'b0;
        step();
        checks++;
        if (q !== 4'hF || qn !== 4'h0) begin
            errors++; $display("FAIL mid_release: q=%b qn=%b expected q=1111", q, qn);
        end
        s = 4'h0; r = 4'hF;
        step();
        r = 4'h0;
    endtask

    task automatic test_independent();
        logic [3:0] s_vec [4];
        logic [3:0] r_vec [4];
        logic [3:0] q_exp [4];
        s_vec = '{4'b0101, 4'b0010, 4'b1000, 4'b0011};
        r_vec = '{4'b0000, 4'b0001, 4'b0100, 4'b0011};
        q_exp = '{4'b0101, 4'b0110, 4'b1010, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            s = s_vec[i]; r = r_vec[i];
            step();
            checks++;
            if (q !== q_exp[i] || qn !== ~q_exp[i]) begin
                errors++; $display("FAIL independent[%0d]: q=%b qn=%b expected q=%b", i, q, qn, q_exp[i]);
            end
        end
        s = 4'h0; r = 4'h0;
    endtask

    initial begin
        rst = 1'b0; s = 4'h0; r = 4'h0; s1 = 1'b0; r1 = 1'b0;
        #2;
        test_reset();
        test_set_hold();
        test_clear_hold();
        test_back_to_back();
        test_glitch();
        test_conflict();
        test_reset_mid();
        test_independent();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
